fetch_predict: RTL and testbench

FETCH_PREDICT -- requirements
Module: fetch_predict

---
 rtl/fetch_predict_pkg.sv | 31 +++
 rtl/fetch_predict_btb.sv | 84 ++++++++
 rtl/fetch_predict.sv | 80 ++++++++
 tb/tb_fetch_predict.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_predict_pkg.sv
// Shared types and constants for the fetch stage and its branch target buffer.
// Counter encoding: SNT/WNT predict not-taken, WT/ST predict taken.
package fetch_predict_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = XLEN - 2;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Tag field is sized for the smallest table; unused upper bits stay zero.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       cnt;
    } btb_entry_t;

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == ST) ? ST : cnt + 2'd1;
        end else begin
            res = (cnt == SNT) ? SNT : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_predict_btb.sv
// Direct-mapped branch target buffer: combinational lookup of the fetch PC and
// single-port update from execute. Lookups see the contents before a same-cycle write.
module fetch_predict_btb
    import fetch_predict_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    if (BTB_ENTRIES < 2 || BTB_ENTRIES > 256 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("BTB_ENTRIES must be a power of two in 2..256");
    end

    btb_entry_t       mem [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    btb_entry_t       lk_e;
    logic             lk_hit;

    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    btb_entry_t       up_e;
    btb_entry_t       up_new;
    logic             up_hit;
    logic             up_we;

    logic             unused_lsb;

    assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX+1:2];
    assign lk_tag = TAG_W'(lookup_pc[XLEN-1:IDX+2]);
    assign lk_e   = mem[lk_idx];
    assign lk_hit = lk_e.valid && (lk_e.tag == lk_tag);

    assign pred_taken  = lk_hit && lk_e.cnt[1];
    assign pred_target = lk_e.target;

    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = TAG_W'(upd_pc[XLEN-1:IDX+2]);
    assign up_e   = mem[up_idx];
    assign up_hit = up_e.valid && (up_e.tag == up_tag);

    // A not-taken outcome on a miss leaves the table untouched.
    assign up_we = upd_en && (up_hit || upd_taken);

    always_comb begin
        up_new = up_e;
        if (up_hit) begin
            up_new.cnt = cnt_next(up_e.cnt, upd_taken);
            if (upd_taken) begin
                up_new.target = upd_target;
            end
        end else begin
            up_new.valid  = 1'b1;
            up_new.tag    = up_tag;
            up_new.target = upd_target;
            up_new.cnt    = WT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (up_we) begin
            mem[up_idx] <= up_new;
        end
    end

endmodule

// File: rtl/fetch_predict.sv
// Fetch stage: PC register, next-PC selection and optional BTB prediction.
// Define FETCH_BTB_EN to build the branch target buffer; otherwise fetch is sequential.
module fetch_predict
    import fetch_predict_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stallF,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_F,
    output logic [XLEN-1:0] pc4_F,
    output logic [XLEN-1:0] instr_F,
    output logic            takenF
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

`ifdef FETCH_BTB_EN
    fetch_predict_btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_pc   (pc_q),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );
`else
    logic unused_upd;

    assign unused_upd  = ^{upd_en, upd_pc, upd_taken, upd_target, 32'(BTB_ENTRIES)};
    assign pred_taken  = 1'b0;
    assign pred_target = '0;
`endif

    assign pc_F      = pc_q;
    assign imem_addr = pc_q;
    assign pc4_F     = pc_q + 32'd4;
    assign instr_F   = imem_rdata;
    assign takenF    = pred_taken;

    // Redirect wins over stall so a flush is never lost while fetch is held.
    always_comb begin
        if (redirect_en) begin
            pc_next = redirect_pc;
        end else if (stallF) begin
            pc_next = pc_q;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end else begin
            pc_next = pc4_F;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: a vector table of per-cycle inputs and expected
// fetch outputs, plus short hand-written reset and stall sequences.
module tb_fetch_predict;

    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam int          ENTRIES = 16;
    localparam logic [31:0] IMEM_XOR = 32'hA5A5_5A5A;
`ifdef FETCH_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallF;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_F;
    logic [31:0] pc4_F;
    logic [31:0] instr_F;
    logic        takenF;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ IMEM_XOR;

    fetch_predict #(
        .RESET_PC    (RST_PC),
        .BTB_ENTRIES (ENTRIES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stallF      (stallF),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc_F        (pc_F),
        .pc4_F       (pc4_F),
        .instr_F     (instr_F),
        .takenF      (takenF)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redir;
        logic [31:0] redir_pc;
        logic        upd;
        logic [31:0] upd_pc;
        logic        upd_tk;
        logic [31:0] upd_tgt;
        logic [31:0] epc_en;
        logic        etk_en;
        logic [31:0] epc_dis;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic r, logic s, logic re, logic [31:0] rpc,
                                logic ue, logic [31:0] upc, logic ut, logic [31:0] utg,
                                logic [31:0] epe, logic etk, logic [31:0] epd);
        vec_t v;
        v.rst_n = r;   v.stall = s;    v.redir = re;  v.redir_pc = rpc;
        v.upd = ue;    v.upd_pc = upc; v.upd_tk = ut; v.upd_tgt = utg;
        v.epc_en = epe; v.etk_en = etk; v.epc_dis = epd;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic check_outputs(input int row, input logic [31:0] epc, input logic etk);
        chk("pc_F", row, pc_F, epc);
        chk("imem_addr", row, imem_addr, epc);
        chk("pc4_F", row, pc4_F, epc + 32'd4);
        chk("instr_F", row, instr_F, epc ^ IMEM_XOR);
        chk("takenF", row, {31'd0, takenF}, {31'd0, etk});
    endtask

    task automatic idle_inputs();
        stallF = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    endtask

    localparam logic [31:0] A  = 32'h0000_0108;
    localparam logic [31:0] TG = 32'h0000_0040;

    initial begin
        logic [31:0] epc;
        logic        etk;

        //                r  s  re rpc           ue upc ut utg   pc_en        tk pc_dis
        vecs[0]  = mk(1, 0, 0, 0,            0, 0, 0, 0,   32'h100,     0, 32'h100);
        vecs[1]  = mk(1, 0, 0, 0,            0, 0, 0, 0,   32'h104,     0, 32'h104);
        vecs[2]  = mk(1, 1, 1, 32'h200,      0, 0, 0, 0,   32'h108,     0, 32'h108);
        vecs[3]  = mk(1, 0, 1, A,            1, A, 1, TG,  32'h200,     0, 32'h200);
        vecs[4]  = mk(1, 0, 0, 0,            0, 0, 0, 0,   A,           1, A);
        vecs[5]  = mk(1, 1, 0, 0,            1, A, 0, 0,   TG,          0, 32'h10C);
        vecs[6]  = mk(1, 0, 1, A,            1, A, 0, 0,   TG,          0, 32'h10C);
        vecs[7]  = mk(1, 0, 1, A,            1, A, 0, 0,   A,           0, A);
        vecs[8]  = mk(1, 0, 1, A,            1, A, 1, TG,  A,           0, A);
        vecs[9]  = mk(1, 0, 1, A,            1, A, 1, TG,  A,           0, A);
        vecs[10] = mk(1, 0, 1, A,            1, A, 1, TG,  A,           1, A);
        vecs[11] = mk(1, 0, 1, A,            1, A, 1, TG,  A,           1, A);
        vecs[12] = mk(1, 0, 1, A,            1, A, 0, 0,   A,           1, A);
        vecs[13] = mk(1, 0, 1, A,            1, A, 0, 0,   A,           1, A);
        vecs[14] = mk(1, 0, 1, A + 4*ENTRIES,0, 0, 0, 0,   A,           0, A);
        vecs[15] = mk(1, 0, 0, 0,            0, 0, 0, 0,   A + 4*ENTRIES, 0, A + 4*ENTRIES);
        vecs[16] = mk(1, 0, 1, 32'hFFFF_FFFC,0, 0, 0, 0,   32'h14C,     0, 32'h14C);
        vecs[17] = mk(1, 0, 0, 0,            0, 0, 0, 0,   32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
        vecs[18] = mk(1, 0, 1, A,            1, A, 1, TG,  32'h0,       0, 32'h0);
        vecs[19] = mk(0, 1, 1, 32'h300,      1, A, 1, TG,  A,           1, A);
        vecs[20] = mk(1, 0, 1, A,            0, 0, 0, 0,   32'h100,     0, 32'h100);
        vecs[21] = mk(1, 0, 0, 0,            0, 0, 0, 0,   A,           0, A);
        vecs[22] = mk(1, 0, 0, 0,            0, 0, 0, 0,   32'h10C,     0, 32'h10C);

        // Reset held for two edges while redirect, stall and a taken update are all
        // asserted: reset must win and the update must not allocate.
        idle_inputs();
        rst_n = 1'b0;
        stallF = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h0000_0500;
        upd_en = 1'b1; upd_pc = A; upd_taken = 1'b1; upd_target = TG;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst_n       = vecs[i].rst_n;
            stallF      = vecs[i].stall;
            redirect_en = vecs[i].redir;
            redirect_pc = vecs[i].redir_pc;
            upd_en      = vecs[i].upd;
            upd_pc      = vecs[i].upd_pc;
            upd_taken   = vecs[i].upd_tk;
            upd_target  = vecs[i].upd_tgt;
            #1;
            epc = BTB_ON ? vecs[i].epc_en : vecs[i].epc_dis;
            etk = BTB_ON ? vecs[i].etk_en : 1'b0;
            check_outputs(i, epc, etk);
        end

        // Stall held over several cycles, then released.
        @(negedge clk);
        idle_inputs();
        stallF = 1'b1;
        #1 check_outputs(100, 32'h110, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check_outputs(101 + k, 32'h110, 1'b0);
        end
        stallF = 1'b0;
        @(negedge clk);
        #1 check_outputs(104, 32'h114, 1'b0);

        // Allocate at A, then a single-cycle reset mid-run must discard it.
        @(negedge clk);
        redirect_en = 1'b1; redirect_pc = A;
        upd_en = 1'b1; upd_pc = A; upd_taken = 1'b1; upd_target = TG;
        @(negedge clk);
        idle_inputs();
        #1 check_outputs(105, A, BTB_ON);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        redirect_en = 1'b1; redirect_pc = A;
        #1 check_outputs(106, RST_PC, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1 check_outputs(107, A, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
